// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// through a single full-subtractor cell and reports diff/borrow with a done pulse.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [WIDTH-2:0]   res_sh;
  logic [WIDTH-1:0]   res_nxt;
  logic               br, br_nxt, d_bit;
  logic [CNT_W-1:0]   cnt;
  logic               accept, last_bit;

  // Returns {borrow_out, difference} for x - y - bin.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d, bo;
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
    return {bo, d};
  endfunction

  assign {br_nxt, d_bit} = full_sub(a_sh[0], b_sh[0], br);
  // The new bit enters at the MSB; the LSB that falls off is never needed.
  assign res_nxt  = {d_bit, res_sh};
  assign accept   = (state != RUN) && start;
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: state_nxt = start ? RUN : IDLE;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt[WIDTH-1:1];
      br     <= br_nxt;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        diff   <= res_nxt;
        borrow <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=4): expected results are queued at
// launch and compared whenever the DUT raises done.
module tb_serial_sub;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];
  logic prev_done = 1'b0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t ref_sub(input int av, input int bv);
    exp_t r;
    r.d  = W'((av - bv + (1 << W)) % (1 << W));
    r.br = (av < bv);
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected result and must be one cycle wide.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: diff=%0d borrow=%0b with no pending operation", diff, borrow);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (diff !== e.d || borrow !== e.br) begin
            errors++;
            $display("FAIL result: got diff=%0d borrow=%0b, expected diff=%0d borrow=%0b",
                     diff, borrow, e.d, e.br);
          end
        end
        checks++;
        if (prev_done === 1'b1) begin
          errors++;
          $display("FAIL done_width: done high for 2+ cycles, expected 1 (cycle %0d)", cyc);
        end
      end
      prev_done = done;
    end
  end

  // Drives one start pulse; k is the accepting edge. Operands scrambled afterwards.
  task automatic launch(input int av, input int bv, input bit push, output int k);
    @(posedge clk); #1;
    a = W'(av); b = W'(bv); start = 1'b1;
    if (push) sb_q.push_back(ref_sub(av, bv));
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(output bit ok, output int dc);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%0d borrow=%b, expected all 0",
               busy, done, diff, borrow);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int ta[5] = '{5, 3, 0, 0, 15};
    int tb[5] = '{3, 5, 1, 0, 15};
    int k, dc;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb[i], 1'b1, k);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy[%0d]: busy=%b, expected 1", i, busy);
      end
      wait_done(ok, dc);
      checks++;
      if (!ok || dc != k + W) begin
        errors++;
        $display("FAIL basic_latency[%0d]: done at cycle %0d, expected %0d", i, dc, k + W);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int k, dc;
    bit ok;
    launch(12, 5, 1'b1, k);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_flag: busy=%b, expected 1", busy);
    end
    start = 1'b1; a = 4'd1; b = 4'd9;
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b0; a = 4'd7; b = 4'd8;
    wait_done(ok, dc);
    checks++;
    if (!ok || dc != k + W) begin
      errors++;
      $display("FAIL busy_latency: done at cycle %0d, expected %0d", dc, k + W);
    end
  endtask

  task automatic test_back_to_back;
    int k1, k2, dc1, dc2;
    bit ok1, ok2;
    launch(9, 4, 1'b1, k1);
    wait_done(ok1, dc1);
    checks++;
    if (!ok1 || dc1 != k1 + W) begin
      errors++;
      $display("FAIL b2b_first: done at cycle %0d, expected %0d", dc1, k1 + W);
    end
    a = 4'd2; b = 4'd7; start = 1'b1;
    sb_q.push_back(ref_sub(2, 7));
    @(posedge clk); #1;
    k2 = cyc;
    start = 1'b0; a = 4'd15; b = 4'd0;
    wait_done(ok2, dc2);
    checks++;
    if (!ok2 || dc2 != dc1 + W + 1) begin
      errors++;
      $display("FAIL b2b_second: done at cycle %0d, expected %0d (accept edge %0d)",
               dc2, dc1 + W + 1, k2);
    end
  endtask

  task automatic test_reset_mid_run;
    int k, dc, seen;
    bit ok;
    launch(6, 2, 1'b0, k);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b diff=%0d borrow=%b, expected all 0",
               busy, done, diff, borrow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_done: %0d done cycles after abort, expected 0", seen);
    end
    launch(6, 2, 1'b1, k);
    wait_done(ok, dc);
    checks++;
    if (!ok || dc != k + W) begin
      errors++;
      $display("FAIL post_reset_latency: done at cycle %0d, expected %0d", dc, k + W);
    end
  endtask

  task automatic test_exhaustive;
    int k, dc;
    bit ok;
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        launch(i, j, 1'b1, k);
        wait_done(ok, dc);
        checks++;
        if (!ok || dc != k + W) begin
          errors++;
          $display("FAIL exh_latency a=%0d b=%0d: done at cycle %0d, expected %0d", i, j, dc, k + W);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
